// File: rtl/rand_value_pool.sv
// rand_value_pool: requests random values over a toggle trigger and keeps a FIFO of unique in-range samples.
module rand_value_pool #(
  parameter int DEPTH     = 8,
  parameter int MIN_VAL   = 1,
  parameter int MAX_VAL   = 127,
  parameter int LATENCY   = 2,
  parameter int MAX_RETRY = 15
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic [7:0]               random_in,
  output logic                     trigger,
  input  logic                     pop,
  output logic [7:0]               value,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     retry_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(LATENCY);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, CHECK = 2'd3;
  logic [1:0]       state_q, state_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [AW-1:0]    head_q, tail_q, head_d;
  logic [AW:0]      count_q;
  logic [DEPTH-1:0] vld_q, vld_d, hit;
  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       value_q;
  logic             trig_q, err_q;
  logic             in_range, check, accept, force_wr, wr, rd;
  // Only slots holding live entries take part in the duplicate screen.
  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    assign hit[i] = vld_q[i] && mem_q[i] == random_in;
  end
  assign in_range = random_in >= 8'(MIN_VAL) && random_in <= 8'(MAX_VAL);
  assign check    = state_q == CHECK;
  assign accept   = check && in_range && !(|hit);
  assign force_wr = check && !accept && retry_q == RW'(MAX_RETRY);
  assign wr       = accept || force_wr;
  assign rd       = pop && valid;
  assign head_d   = head_q + AW'(rd);
  always_comb begin
    state_d = state_q == IDLE ? (count_q < (AW+1)'(DEPTH) ? REQ : IDLE) :
              state_q == REQ  ? WAIT :
              state_q == WAIT ? (wait_q == '0 ? CHECK : WAIT) :
              (wr ? IDLE : REQ);
    wait_d  = state_q == REQ ? WW'(LATENCY - 1) :
              (state_q == WAIT && wait_q != '0) ? wait_q - WW'(1) : wait_q;
    retry_d = wr ? '0 : check ? retry_q + RW'(1) : retry_q;
    vld_d   = (vld_q & ~(DEPTH'(rd) << head_q)) | (DEPTH'(wr) << tail_q);
  end
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= IDLE;
      wait_q  <= '0;
      retry_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
      value_q <= '0;
      trig_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      retry_q <= retry_d;
      head_q  <= head_d;
      tail_q  <= tail_q + AW'(wr);
      count_q <= count_q + (AW+1)'(wr) - (AW+1)'(rd);
      vld_q   <= vld_d;
      // A write landing on the new head bypasses storage so value stays current.
      value_q <= (wr && head_d == tail_q) ? random_in : mem_q[head_d];
      trig_q  <= trig_q ^ (state_q == REQ);
      err_q   <= err_q | force_wr;
    end
  end
  always_ff @(posedge CLOCK) begin
    if (wr) mem_q[tail_q] <= random_in;
  end
  assign trigger   = trig_q;
  assign value     = value_q;
  assign count     = count_q;
  assign valid     = count_q != '0;
  assign full      = count_q == (AW+1)'(DEPTH);
  assign retry_err = err_q;
endmodule

// File: tb/tb_rand_value_pool.sv
// tb_rand_value_pool: directed checks of request timing, screening, FIFO order, retry limit and reset.
module tb_rand_value_pool;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] random_in = 8'd40;
  logic       trigger, pop = 1'b0, valid, full, retry_err;
  logic [7:0] value;
  logic [3:0] count;
  int         n_cmp = 0, n_err = 0, toggles = 0, base;
  logic       trig_prev = 1'b0;
  int         q[$];
  int         dflt = 40;

  rand_value_pool dut (
    .CLOCK(clk), .RESET(rst), .random_in(random_in), .trigger(trigger), .pop(pop),
    .value(value), .valid(valid), .count(count), .full(full), .retry_err(retry_err)
  );

  always #5 clk = ~clk;

  // Generator model: each request toggle presents the next scripted value.
  always @(negedge clk) begin
    if (!rst && trigger !== trig_prev) begin
      toggles++;
      random_in = q.size() ? 8'(q.pop_front()) : 8'(dflt);
    end
    trig_prev = trigger;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick;
    rst = 1'b0;
    base = toggles;
  endtask

  task automatic wait_count(input string tag, input int c, input int lim);
    int n = 0;
    while (count !== 4'(c) && n < lim) begin
      tick;
      n++;
    end
    check(tag, int'(count), c);
  endtask

  initial begin
    // Reset, first request timing, duplicate re-request
    do_reset(3);
    check("rst_trigger", int'(trigger), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_count", int'(count), 0);
    check("rst_full", int'(full), 0);
    check("rst_err", int'(retry_err), 0);
    check("rst_value", int'(value), 0);
    tick;
    check("t1_trig_c1", int'(trigger), 0);
    tick;
    check("t1_trig_c2", int'(trigger), 1);
    tick;
    tick;
    check("t1_valid_c4", int'(valid), 0);
    tick;
    check("t1_valid_c5", int'(valid), 1);
    check("t1_value", int'(value), 40);
    tick;
    tick;
    check("t1_retoggle", int'(trigger), 0);

    // Range and duplicate screening, FIFO order
    q = {5, 9, 130, 9, 12};
    dflt = 200;
    do_reset(1);
    wait_count("t2_fill", 3, 100);
    check("t2_toggles", toggles - base, 5);
    check("t2_head", int'(value), 5);
    pop = 1'b1;
    tick;
    check("t2_pop1", int'(value), 9);
    tick;
    check("t2_pop2", int'(value), 12);
    tick;
    pop = 1'b0;
    check("t2_empty_valid", int'(valid), 0);
    check("t2_empty_count", int'(count), 0);

    // Fill to full, refill one slot, tail wraps
    q = {1, 2, 3, 4, 5, 6, 7, 8};
    dflt = 1;
    do_reset(1);
    wait_count("t3_fill", 8, 100);
    check("t3_full", int'(full), 1);
    check("t3_toggles", toggles - base, 8);
    repeat (10) tick;
    check("t3_idle_toggles", toggles - base, 8);
    dflt = 9;
    pop = 1'b1;
    tick;
    pop = 1'b0;
    check("t3_head2", int'(value), 2);
    wait_count("t3_refill", 8, 20);
    check("t3_one_toggle", toggles - base, 9);
    dflt = 0;
    pop = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick;
      check($sformatf("t3_drain%0d", k), int'(value), k + 2);
    end
    pop = 1'b0;
    check("t3_drain_count", int'(count), 1);

    // Retry limit forces a write and latches the error
    q = {};
    dflt = 0;
    do_reset(1);
    wait_count("t4_forced", 1, 200);
    check("t4_err", int'(retry_err), 1);
    check("t4_toggles", toggles - base, 16);
    check("t4_value", int'(value), 0);
    dflt = 77;
    wait_count("t4_resume", 2, 30);
    check("t4_toggles2", toggles - base, 17);
    check("t4_err_sticky", int'(retry_err), 1);
    pop = 1'b1;
    tick;
    pop = 1'b0;
    check("t4_pop_value", int'(value), 77);

    // Entry popped during CHECK still counts as a duplicate
    q = {5, 7, 5};
    dflt = 200;
    do_reset(1);
    wait_count("t5_fill", 2, 50);
    for (int n = 0; toggles - base < 3 && n < 20; n++) tick;
    check("t5_third_req", toggles - base, 3);
    tick;
    tick;
    pop = 1'b1;
    tick;
    pop = 1'b0;
    check("t5_count", int'(count), 1);
    check("t5_value", int'(value), 7);
    tick;
    check("t5_rerequest", toggles - base, 4);

    // Reset in WAIT abandons the request
    q = {};
    dflt = 50;
    do_reset(1);
    for (int n = 0; toggles - base < 1 && n < 20; n++) tick;
    check("t6_req", toggles - base, 1);
    rst = 1'b1;
    tick;
    random_in = 8'd99;
    check("t6_trigger", int'(trigger), 0);
    check("t6_count", int'(count), 0);
    check("t6_valid", int'(valid), 0);
    rst = 1'b0;
    base = toggles;
    tick;
    tick;
    check("t6_no_late_write", int'(count), 0);
    wait_count("t6_restart", 1, 20);
    check("t6_value", int'(value), 50);
    check("t6_toggles", toggles - base, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
